matrix_row_shifter: RTL and testbench
=====================================

# matrix_row_shifter

Sequential consumer of per-column pixel colour. On a `start` pulse it walks `column_address` from 0 to `COLUMNS-1`. For each column it samples the 6-bit `red`/`green`/`blue` values returned combinationally for that address (for example by the rainbow gradient source), selects one bit plane, and shifts that bit out to the LED panel's serial RGB inputs with a pixel clock. After the last column it pulses the panel latch. It sits between the colour source and the panel pins; row selection and output enable are owned by the scan controller that issues `start`.

## Interface
- `COLUMNS`, 64, number of columns shifted per row; legal range 1..64.
- `BIT_DEPTH`, 6, width of each colour channel; bit planes 0..BIT_DEPTH-1 are valid.

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request one row shift; sampled only in IDLE.
- `bit_plane`  in  3  plane to shift; captured on accepted `start`.
- `column_address`  out  6  column currently being sampled; registered.
- `red`, `green`, `blue`  in  6 each  colour for `column_address`; valid in the same cycle.
- `pixel_rgb`  out  3  {R,G,B} serial data to panel; registered.
- `pixel_clock`  out  1  panel shift clock; registered.
- `pixel_latch`  out  1  panel latch strobe; registered.
- `busy`  out  1  high while a row is in progress.
- `done`  out  1  one-cycle pulse after the latch.

## Operation
- States: IDLE, LOAD, SETUP, HIGH, LATCH, DONE.
- IDLE:
  - `column_address`=0, `pixel_clock`=0, `busy`=0.
  - `start`=1 captures `bit_plane` into `plane_q`, clears the column counter, and moves to LOAD.
- LOAD:
  - `column_address`=col, `pixel_clock`=0.
  - At the end of the cycle, `pixel_rgb` <= {red[plane_q], green[plane_q], blue[plane_q]}.
  - If `plane_q` >= `BIT_DEPTH`, load 3'b000 instead.
- SETUP: `pixel_clock`=0; `pixel_rgb` is stable with the new data. Next state is HIGH.
- HIGH:
  - `pixel_clock`=1.
  - If col = `COLUMNS-1`, next state is LATCH; otherwise col <= col+1 and next state is LOAD.
- LATCH: `pixel_latch`=1, `pixel_clock`=0, `pixel_rgb` holds the last column's data. Next state is DONE.
- DONE: `done`=1, `busy`=0, `pixel_latch`=0. Behaves exactly as IDLE, including accepting `start`. Next state is IDLE, or LOAD if `start` is high.
- `busy`=1 in LOAD, SETUP, HIGH and LATCH.
- `start` outside IDLE/DONE is ignored; no queuing.
- `bit_plane` changes after capture have no effect.
- Column counter width is 6 bits. It never wraps, because LATCH is taken at `COLUMNS-1`.
- `pixel_rgb` keeps its last value in IDLE and changes only in LOAD.
- Reset, whether in IDLE or mid-row, returns to IDLE in the next cycle with no latch pulse and no `done`.
- Reset values:
  - `column_address`=0, `pixel_rgb`=0, `pixel_clock`=0, `pixel_latch`=0, `busy`=0, `done`=0.
  - Internal: `plane_q`=0, counter=0.

## Timing
- `start` sampled high at edge 0 → cycle 1 is LOAD col 0.
- Column c occupies cycles 3c+1 (LOAD), 3c+2 (SETUP) and 3c+3 (HIGH).
- Data setup and hold around each clock pulse:
  - `pixel_rgb` changes only at the LOAD→SETUP edge.
  - This gives 1 cycle of setup before `pixel_clock` rises.
  - It gives 1 cycle of hold (the next LOAD) after `pixel_clock` falls.
- With `COLUMNS`=64: LATCH in cycle 193, `done` in cycle 194, `busy` high in cycles 1..193.
- Back-to-back: `start` held high in cycle 194 (DONE) → LOAD col 0 in cycle 195, so the row period is 194 cycles.
- Exactly `COLUMNS` rising edges of `pixel_clock` per row, each high for 1 cycle. Exactly one `pixel_latch` cycle per completed row.

## Test plan
- Reset check: assert `reset` for 2 cycles → every output is 0 and the block is in IDLE; a `start` in the first cycle after reset is accepted.
- Bench model: drive `red`/`green`/`blue` from the rainbow gradient model, run `bit_plane`=0 and `bit_plane`=5, and compare the captured 64-bit streams with the model.
  - At col 10: red=33, green=0, blue=32.
  - Plane 0 → `pixel_rgb`=3'b100.
  - Plane 5 → `pixel_rgb`=3'b101.
  - Plane 1 → `pixel_rgb`=3'b000.
- Cycle count: `start` at edge 0 →
  - exactly 64 `pixel_clock` pulses;
  - `pixel_latch` only in cycle 193;
  - `done` only in cycle 194;
  - `busy` falls in cycle 194;
  - `pixel_rgb` is stable during every SETUP and HIGH cycle.
- Start and plane handling:
  - Pulse `start` and change `bit_plane` at cycles 50 and 120 → no restart, and the plane stays the one originally captured.
  - `bit_plane`=6 or 7 → all 64 shifted bits are 0, but clock and latch still occur.
- Reset mid-row: assert `reset` at cycle 100 → IDLE on the next cycle, no `pixel_latch`, no `done`, all outputs 0. A new `start` then completes a full 64-column row normally.
- `COLUMNS`=1 build: `start` → LOAD, SETUP, HIGH, then LATCH in cycle 4 and `done` in cycle 5.

Source files
------------

// File: rtl/matrix_row_shifter.sv
// matrix_row_shifter: walks one row of COLUMNS pixels, samples the colour
// source for each column, picks one bit plane and shifts it out to an LED
// panel with a pixel clock, then strobes the panel latch.
//
// Handshake: start is a request with no ready signal. It is accepted only
// in the cycle the block reports busy=0 (IDLE or DONE). A start seen while
// busy=1 is dropped, never queued. The bit_plane value present at the
// accepting edge is the plane used for the whole row.
//
// Per-column cadence is LOAD -> SETUP -> HIGH:
//   LOAD  : column_address presents the column and the colour source answers
//           combinationally; pixel_rgb is loaded at the end of this cycle.
//   SETUP : data is stable on the pins with pixel_clock low (setup time).
//   HIGH  : pixel_clock high for one cycle. The following LOAD keeps the data
//           unchanged, which gives one cycle of hold after the falling edge.
// After the last column's HIGH the block spends one cycle in LATCH
// (pixel_latch=1), then one cycle in DONE (done=1). DONE accepts start
// exactly like IDLE, so rows can run back to back with no gap cycle.
//
// Every output is a register that is loaded with the value belonging to the
// state being entered, so all pins change cleanly on the clock edge.
module matrix_row_shifter #(
  parameter int COLUMNS   = 64,
  parameter int BIT_DEPTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           bit_plane,
  output logic [5:0]           column_address,
  input  logic [BIT_DEPTH-1:0] red,
  input  logic [BIT_DEPTH-1:0] green,
  input  logic [BIT_DEPTH-1:0] blue,
  output logic [2:0]           pixel_rgb,
  output logic                 pixel_clock,
  output logic                 pixel_latch,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  // IDLE is encoded as zero so a cleared state register reads as IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    HIGH  = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [5:0] LAST_COL = 6'(COLUMNS - 1);

  state_t     state;
  logic [2:0] plane_q;
  logic [5:0] col_q;
  logic [2:0] sel_rgb;

  // Bit-plane select: planes at or above BIT_DEPTH match no channel bit and
  // therefore shift zeros, while the clock and latch sequence is unchanged.
  always_comb begin
    sel_rgb = 3'b000;
    for (int i = 0; i < BIT_DEPTH; i++) begin
      if (plane_q == 3'(i)) begin
        sel_rgb = {red[i], green[i], blue[i]};
      end
    end
  end

  // Row sequencer: state, column counter, captured plane and all pin registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      plane_q        <= 3'd0;
      col_q          <= 6'd0;
      column_address <= 6'd0;
      pixel_rgb      <= 3'b000;
      pixel_clock    <= 1'b0;
      pixel_latch    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the LATCH branch raises it.
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          column_address <= 6'd0;
          pixel_clock    <= 1'b0;
          pixel_latch    <= 1'b0;
          if (start) begin
            plane_q <= bit_plane;
            col_q   <= 6'd0;
            busy    <= 1'b1;
            state   <= LOAD;
          end else begin
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        LOAD: begin
          // The only place the serial data pins are updated.
          pixel_rgb <= sel_rgb;
          state     <= SETUP;
        end
        SETUP: begin
          pixel_clock <= 1'b1;
          state       <= HIGH;
        end
        HIGH: begin
          pixel_clock <= 1'b0;
          if (col_q == LAST_COL) begin
            // Counter stops at the last column, so it never wraps.
            pixel_latch <= 1'b1;
            state       <= LATCH;
          end else begin
            col_q          <= col_q + 6'd1;
            column_address <= col_q + 6'd1;
            state          <= LOAD;
          end
        end
        LATCH: begin
          pixel_latch    <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b1;
          column_address <= 6'd0;
          state          <= DONE;
        end
        default: begin
          pixel_clock <= 1'b0;
          pixel_latch <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_matrix_row_shifter.sv
// Bench for matrix_row_shifter: a 64-column instance driven by a rainbow
// gradient colour model, and a 1-column instance for the single-column case.
module tb_matrix_row_shifter;

  localparam int COLS = 64;
  localparam int ROW  = 3 * COLS + 2;  // cycle index of DONE for a row started at edge 0

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] bit_plane = 3'd0;
  logic [5:0] column_address;
  logic [5:0] red, green, blue;
  logic [2:0] pixel_rgb;
  logic       pixel_clock, pixel_latch, busy, done;
  logic [2:0] state_dbg;

  logic       start1 = 1'b0;
  logic [2:0] bit_plane1 = 3'd0;
  logic [5:0] column_address1;
  logic [5:0] red1, green1, blue1;
  logic [2:0] pixel_rgb1;
  logic       pixel_clock1, pixel_latch1, busy1, done1;
  logic [2:0] state_dbg1;

  matrix_row_shifter #(.COLUMNS(COLS), .BIT_DEPTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_plane(bit_plane),
    .column_address(column_address), .red(red), .green(green), .blue(blue),
    .pixel_rgb(pixel_rgb), .pixel_clock(pixel_clock), .pixel_latch(pixel_latch),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  matrix_row_shifter #(.COLUMNS(1), .BIT_DEPTH(6)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bit_plane(bit_plane1),
    .column_address(column_address1), .red(red1), .green(green1), .blue(blue1),
    .pixel_rgb(pixel_rgb1), .pixel_clock(pixel_clock1), .pixel_latch(pixel_latch1),
    .busy(busy1), .done(done1), .state_dbg(state_dbg1)
  );

  // ---------------- colour model ----------------
  // Three-segment gradient red->blue->green->red. Column 10 gives 33/0/32.
  function automatic logic [17:0] rainbow(input int c);
    int r, g, b;
    if (c <= 20) begin
      r = 63 - 3 * c; g = 0; b = 3 * c + 2;
    end else if (c <= 41) begin
      r = 0; g = 3 * (c - 21) + 2; b = 63 - 3 * (c - 21);
    end else begin
      r = 3 * (c - 42) + 2; if (r > 63) r = 63;
      g = 63 - 3 * (c - 42); b = 0;
    end
    return {6'(r), 6'(g), 6'(b)};
  endfunction

  function automatic logic [2:0] exp_bits(input int c, input logic [2:0] p);
    logic [17:0] v;
    logic [5:0]  r, g, b;
    v = rainbow(c);
    r = v[17:12] >> p;
    g = v[11:6] >> p;
    b = v[5:0] >> p;
    return {r[0], g[0], b[0]};
  endfunction

  always_comb {red, green, blue} = rainbow(int'(column_address));
  always_comb {red1, green1, blue1} = rainbow(int'(column_address1));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp1_q[$];

  // Every pixel_clock-high cycle pops one expected bit triple.
  always @(negedge clk) begin : mon
    logic [2:0] e;
    if (!reset && pixel_clock) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: pulse at col %0d rgb=%b, required no pulse", column_address, pixel_rgb);
      end else begin
        e = exp_q.pop_front();
        if (pixel_rgb !== e) begin
          bad++;
          $display("FAIL stream_bit: col %0d got rgb=%b, required %b", column_address, pixel_rgb, e);
        end
      end
    end
    if (!reset && pixel_clock1) begin
      total++;
      if (exp1_q.size() == 0) begin
        bad++;
        $display("FAIL stream1_extra: rgb=%b, required no pulse", pixel_rgb1);
      end else begin
        e = exp1_q.pop_front();
        if (pixel_rgb1 !== e) begin
          bad++;
          $display("FAIL stream1_bit: got rgb=%b, required %b", pixel_rgb1, e);
        end
      end
    end
  end

  // ---------------- per-cycle logs ----------------
  logic       busy_log [0:399];
  logic       clk_log  [0:399];
  logic       latch_log[0:399];
  logic       done_log [0:399];
  logic [5:0] col_log  [0:399];
  logic [2:0] rgb_log  [0:399];
  logic [2:0] st_log   [0:399];

  function automatic int count_high(input int which, input int from, input int to);
    int cnt = 0;
    for (int n = from; n <= to; n++) begin
      case (which)
        0: cnt += int'(clk_log[n]);
        1: cnt += int'(latch_log[n]);
        2: cnt += int'(done_log[n]);
        default: cnt += int'(busy_log[n]);
      endcase
    end
    return cnt;
  endfunction

  // rgb may only change in SETUP cycles (3c+2 after the start edge).
  function automatic int rgb_bad(input int from, input int to);
    int cnt = 0;
    for (int n = from; n <= to; n++)
      if (rgb_log[n] !== rgb_log[n-1] && (n % 3) != 2) cnt++;
    return cnt;
  endfunction

  function automatic int clk_runs(input int from, input int to);
    int cnt = 0;
    for (int n = from; n <= to; n++)
      if (clk_log[n] && clk_log[n-1]) cnt++;
    return cnt;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; start is sampled at the next posedge (edge 0) and
  // log index n holds the sample taken during cycle n.
  task automatic run_row(input logic [2:0] plane, input logic [2:0] plane2,
                         input bit disturb, input bit chain,
                         input int reset_at, input int ncyc);
    rgb_log[0] = pixel_rgb;
    clk_log[0] = pixel_clock;
    for (int c = 0; c < COLS; c++) exp_q.push_back(exp_bits(c, plane));
    start = 1'b1;
    bit_plane = plane;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      busy_log[n] = busy; clk_log[n] = pixel_clock; latch_log[n] = pixel_latch;
      done_log[n] = done; col_log[n] = column_address; rgb_log[n] = pixel_rgb;
      st_log[n] = state_dbg;
      start = 1'b0;
      if (disturb && (n == 50 || n == 120)) begin
        start = 1'b1;
        bit_plane = ~plane;
      end
      if (chain && n == ROW) begin
        for (int c = 0; c < COLS; c++) exp_q.push_back(exp_bits(c, plane2));
        start = 1'b1;
        bit_plane = plane2;
      end
      if (n == reset_at) reset = 1'b1;
      else if (n == reset_at + 1) reset = 1'b0;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (column_address !== 6'd0) begin bad++; $display("FAIL reset_col: got %0d, required 0", column_address); end
    total++; if (pixel_rgb !== 3'b000) begin bad++; $display("FAIL reset_rgb: got %b, required 000", pixel_rgb); end
    total++; if (pixel_clock !== 1'b0) begin bad++; $display("FAIL reset_pclk: got %b, required 0", pixel_clock); end
    total++; if (pixel_latch !== 1'b0) begin bad++; $display("FAIL reset_latch: got %b, required 0", pixel_latch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", done); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE); end
    // start in the very first cycle after reset releases
    reset = 1'b0;
    run_row(3'd0, 3'd0, 1'b0, 1'b0, 0, ROW + 2);
    total++; if (st_log[1] !== ST_LOAD || busy_log[1] !== 1'b1 || col_log[1] !== 6'd0) begin
      bad++; $display("FAIL reset_first_start: cycle1 state=%0d busy=%b col=%0d, required state=1 busy=1 col=0", st_log[1], busy_log[1], col_log[1]);
    end
    total++; if (count_high(0, 1, ROW + 2) != COLS) begin bad++; $display("FAIL reset_row_pulses: got %0d, required %0d", count_high(0, 1, ROW + 2), COLS); end
  endtask

  task automatic test_planes();
    logic [2:0] planes[3] = '{3'd0, 3'd5, 3'd1};
    logic [2:0] want[3]   = '{3'b100, 3'b101, 3'b000};
    for (int i = 0; i < 3; i++) begin
      run_row(planes[i], 3'd0, 1'b0, 1'b0, 0, ROW + 2);
      // cycle 33 is the HIGH cycle of column 10
      total++; if (clk_log[33] !== 1'b1 || col_log[33] !== 6'd10) begin
        bad++; $display("FAIL col10_pos: pclk=%b col=%0d, required pclk=1 col=10", clk_log[33], col_log[33]);
      end
      total++; if (rgb_log[33] !== want[i]) begin
        bad++; $display("FAIL col10_plane%0d: got %b, required %b", planes[i], rgb_log[33], want[i]);
      end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL planes_drain: %0d left, required 0", exp_q.size()); end
    end
  endtask

  task automatic test_cycle_count();
    run_row(3'd4, 3'd0, 1'b0, 1'b0, 0, ROW + 2);
    total++; if (count_high(0, 1, ROW + 2) != COLS) begin bad++; $display("FAIL cc_pulses: got %0d, required %0d", count_high(0, 1, ROW + 2), COLS); end
    total++; if (clk_runs(1, ROW + 2) != 0) begin bad++; $display("FAIL cc_pulse_width: got %0d long pulses, required 0", clk_runs(1, ROW + 2)); end
    total++; if (count_high(1, 1, ROW + 2) != 1 || latch_log[193] !== 1'b1) begin
      bad++; $display("FAIL cc_latch: count=%0d at193=%b, required count=1 at193=1", count_high(1, 1, ROW + 2), latch_log[193]);
    end
    total++; if (count_high(2, 1, ROW + 2) != 1 || done_log[194] !== 1'b1) begin
      bad++; $display("FAIL cc_done: count=%0d at194=%b, required count=1 at194=1", count_high(2, 1, ROW + 2), done_log[194]);
    end
    total++; if (count_high(3, 1, 193) != 193 || busy_log[194] !== 1'b0) begin
      bad++; $display("FAIL cc_busy: high=%0d at194=%b, required high=193 at194=0", count_high(3, 1, 193), busy_log[194]);
    end
    total++; if (rgb_bad(1, ROW + 2) != 0) begin bad++; $display("FAIL cc_rgb_stable: got %0d bad changes, required 0", rgb_bad(1, ROW + 2)); end
  endtask

  task automatic test_ignore_start();
    run_row(3'd2, 3'd0, 1'b1, 1'b0, 0, ROW + 2);
    total++; if (col_log[52] !== 6'd17 || col_log[121] !== 6'd40) begin
      bad++; $display("FAIL ign_no_restart: col52=%0d col121=%0d, required 17 and 40", col_log[52], col_log[121]);
    end
    total++; if (count_high(2, 1, ROW + 2) != 1 || done_log[194] !== 1'b1) begin
      bad++; $display("FAIL ign_done: count=%0d at194=%b, required count=1 at194=1", count_high(2, 1, ROW + 2), done_log[194]);
    end
    total++; if (count_high(0, 1, ROW + 2) != COLS) begin bad++; $display("FAIL ign_pulses: got %0d, required %0d", count_high(0, 1, ROW + 2), COLS); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ign_drain: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_plane_out_of_range();
    for (int p = 6; p <= 7; p++) begin
      run_row(3'(p), 3'd0, 1'b0, 1'b0, 0, ROW + 2);
      total++; if (count_high(0, 1, ROW + 2) != COLS) begin bad++; $display("FAIL oor%0d_pulses: got %0d, required %0d", p, count_high(0, 1, ROW + 2), COLS); end
      total++; if (count_high(1, 1, ROW + 2) != 1 || latch_log[193] !== 1'b1) begin
        bad++; $display("FAIL oor%0d_latch: count=%0d at193=%b, required count=1 at193=1", p, count_high(1, 1, ROW + 2), latch_log[193]);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    run_row(3'd3, 3'd0, 1'b0, 1'b0, 100, 120);
    total++; if (st_log[101] !== ST_IDLE || busy_log[101] !== 1'b0 || col_log[101] !== 6'd0) begin
      bad++; $display("FAIL mid_reset_idle: state=%0d busy=%b col=%0d, required 0 0 0", st_log[101], busy_log[101], col_log[101]);
    end
    total++; if (rgb_log[101] !== 3'b000 || clk_log[101] !== 1'b0 || latch_log[101] !== 1'b0 || done_log[101] !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outs: rgb=%b pclk=%b latch=%b done=%b, required all 0", rgb_log[101], clk_log[101], latch_log[101], done_log[101]);
    end
    total++; if (count_high(1, 1, 120) != 0 || count_high(2, 1, 120) != 0) begin
      bad++; $display("FAIL mid_reset_no_latch: latch=%0d done=%0d, required 0 0", count_high(1, 1, 120), count_high(2, 1, 120));
    end
    exp_q.delete();
    run_row(3'd3, 3'd0, 1'b0, 1'b0, 0, ROW + 2);
    total++; if (count_high(0, 1, ROW + 2) != COLS || done_log[194] !== 1'b1 || latch_log[193] !== 1'b1) begin
      bad++; $display("FAIL mid_reset_rerun: pulses=%0d latch193=%b done194=%b, required %0d 1 1", count_high(0, 1, ROW + 2), latch_log[193], done_log[194], COLS);
    end
  endtask

  task automatic test_back_to_back();
    run_row(3'd5, 3'd1, 1'b0, 1'b1, 0, 2 * ROW + 2);
    total++; if (busy_log[194] !== 1'b0 || done_log[194] !== 1'b1) begin
      bad++; $display("FAIL b2b_done1: busy=%b done=%b at 194, required 0 1", busy_log[194], done_log[194]);
    end
    total++; if (st_log[195] !== ST_LOAD || busy_log[195] !== 1'b1 || col_log[195] !== 6'd0) begin
      bad++; $display("FAIL b2b_restart: state=%0d busy=%b col=%0d at 195, required 1 1 0", st_log[195], busy_log[195], col_log[195]);
    end
    total++; if (count_high(0, 1, 2 * ROW + 2) != 2 * COLS) begin bad++; $display("FAIL b2b_pulses: got %0d, required %0d", count_high(0, 1, 2 * ROW + 2), 2 * COLS); end
    total++; if (count_high(1, 1, 2 * ROW + 2) != 2 || latch_log[387] !== 1'b1) begin
      bad++; $display("FAIL b2b_latch: count=%0d at387=%b, required 2 1", count_high(1, 1, 2 * ROW + 2), latch_log[387]);
    end
    total++; if (count_high(2, 1, 2 * ROW + 2) != 2 || done_log[388] !== 1'b1) begin
      bad++; $display("FAIL b2b_done2: count=%0d at388=%b, required 2 1", count_high(2, 1, 2 * ROW + 2), done_log[388]);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_columns_one();
    logic [2:0] st1[1:7];
    logic       l1[1:7];
    logic       d1[1:7];
    int         lc, dc;
    exp1_q.push_back(exp_bits(0, 3'd0));
    start1 = 1'b1;
    bit_plane1 = 3'd0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      st1[n] = state_dbg1; l1[n] = pixel_latch1; d1[n] = done1;
      start1 = 1'b0;
    end
    lc = 0; dc = 0;
    for (int n = 1; n <= 7; n++) begin lc += int'(l1[n]); dc += int'(d1[n]); end
    total++; if (st1[1] !== ST_LOAD || st1[2] !== ST_SETUP || st1[3] !== ST_HIGH) begin
      bad++; $display("FAIL one_seq: states %0d %0d %0d, required 1 2 3", st1[1], st1[2], st1[3]);
    end
    total++; if (lc != 1 || l1[4] !== 1'b1) begin bad++; $display("FAIL one_latch: count=%0d at4=%b, required 1 1", lc, l1[4]); end
    total++; if (dc != 1 || d1[5] !== 1'b1) begin bad++; $display("FAIL one_done: count=%0d at5=%b, required 1 1", dc, d1[5]); end
    total++; if (exp1_q.size() != 0) begin bad++; $display("FAIL one_drain: %0d left, required 0", exp1_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_planes();
    test_cycle_count();
    test_ignore_start();
    test_plane_out_of_range();
    test_reset_mid_row();
    test_back_to_back();
    test_columns_one();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
